// File: rtl/updown_counter_mode.sv
// Parametrised up/down/load counter with wrap, saturate, auto-reload and
// one-shot boundary modes, compare output and sticky boundary flags.
module updown_counter_mode #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  loadin,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              clr_flags,
    input  logic [WIDTH-1:0]  cmp_val,
    output logic [WIDTH-1:0]  y,
    output logic              tc,
    output logic              ovf,
    output logic              udf,
    output logic              done,
    output logic              match
);

    typedef enum logic [1:0] {
        M_WRAP   = 2'b00,
        M_SAT    = 2'b01,
        M_RELOAD = 2'b10,
        M_ONESHOT = 2'b11
    } mode_e;

    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MODV = MAXV + 1'b1;
    localparam logic [WIDTH-1:0] MAXY = WIDTH'(MAX_VAL);

    mode_e            md;
    logic [WIDTH:0]   y_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] load_val;
    logic             counting;
    logic             up_evt;
    logic             dn_evt;

    logic [WIDTH-1:0] y_n;
    logic             tc_n;
    logic             ovf_n;
    logic             udf_n;
    logic             done_n;

    assign md       = mode_e'(mode);
    assign y_ext    = {1'b0, y};
    assign step_ext = (WIDTH+1)'(step);
    assign sum      = y_ext + step_ext;
    assign load_val = (loadin > MAXY) ? MAXY : loadin;
    assign counting = en && (step != '0) && !done;
    assign up_evt   = up && (sum > MAXV);
    assign dn_evt   = !up && (y_ext < step_ext);

    // Compare against the registered count, no extra latency.
    assign match = (y == cmp_val);

    // Next-state selection: load, then counting with boundary handling.
    always_comb begin
        y_n    = y;
        tc_n   = 1'b0;
        ovf_n  = ovf & ~clr_flags;
        udf_n  = udf & ~clr_flags;
        done_n = done;
        if (load) begin
            y_n    = load_val;
            done_n = 1'b0;
        end else if (counting) begin
            if (up_evt || dn_evt) begin
                tc_n  = 1'b1;
                ovf_n = ovf_n | up_evt;
                udf_n = udf_n | dn_evt;
                unique case (md)
                    M_WRAP: begin
                        if (up) y_n = WIDTH'(sum - MODV);
                        else    y_n = WIDTH'(y_ext + MODV - step_ext);
                    end
                    M_SAT: begin
                        y_n = up ? MAXY : '0;
                    end
                    M_RELOAD: begin
                        y_n = load_val;
                    end
                    M_ONESHOT: begin
                        y_n    = up ? MAXY : '0;
                        done_n = 1'b1;
                    end
                endcase
            end else begin
                if (up) y_n = WIDTH'(sum);
                else    y_n = WIDTH'(y_ext - step_ext);
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
            done <= 1'b0;
        end else begin
            y    <= y_n;
            tc   <= tc_n;
            ovf  <= ovf_n;
            udf  <= udf_n;
            done <= done_n;
        end
    end

endmodule

// File: tb/tb_updown_counter_mode.sv
// Directed bench for updown_counter_mode (WIDTH=8, MAX_VAL=99, STEP_W=4).
// Expected outputs are queued as each step is driven and checked after the edge.
module tb_updown_counter_mode;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] loadin;
    logic [3:0] step;
    logic [1:0] mode;
    logic       clr_flags;
    logic [7:0] cmp_val;
    logic [7:0] y;
    logic       tc;
    logic       ovf;
    logic       udf;
    logic       done;
    logic       match;

    typedef struct packed {
        logic [7:0] y;
        logic       tc;
        logic       ovf;
        logic       udf;
        logic       done;
        logic       match;
    } exp_t;

    exp_t  eq[$];
    string tq[$];
    int    tests;
    int    fails;

    updown_counter_mode #(
        .WIDTH(8),
        .MAX_VAL(99),
        .STEP_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .up(up),
        .load(load),
        .loadin(loadin),
        .step(step),
        .mode(mode),
        .clr_flags(clr_flags),
        .cmp_val(cmp_val),
        .y(y),
        .tc(tc),
        .ovf(ovf),
        .udf(udf),
        .done(done),
        .match(match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    // Push the expectation, clock once, then pop and compare.
    task automatic cyc(input string tag, input logic [7:0] ey,
                       input logic etc, input logic eovf, input logic eudf,
                       input logic edone, input logic ematch);
        exp_t e;
        string t;
        eq.push_back('{ey, etc, eovf, eudf, edone, ematch});
        tq.push_back(tag);
        @(posedge clk);
        #1;
        e = eq.pop_front();
        t = tq.pop_front();
        chk({t, ".y"},     y,            e.y);
        chk({t, ".tc"},    {7'd0, tc},   {7'd0, e.tc});
        chk({t, ".ovf"},   {7'd0, ovf},  {7'd0, e.ovf});
        chk({t, ".udf"},   {7'd0, udf},  {7'd0, e.udf});
        chk({t, ".done"},  {7'd0, done}, {7'd0, e.done});
        chk({t, ".match"}, {7'd0, match}, {7'd0, e.match});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1; en = 1; up = 1; load = 1; loadin = 8'd50; step = 4'd3;
        mode = 2'b00; clr_flags = 0; cmp_val = 8'd0;
        @(negedge clk);
        //              y    tc ov ud dn m
        cyc("rst",      0,   0, 0, 0, 0, 1);

        rst = 0; load = 1; loadin = 98; en = 0;
        cyc("ld98",     98,  0, 0, 0, 0, 0);
        load = 0; mode = 2'b00; up = 1; step = 3; en = 1;
        cyc("wrap_up",  1,   1, 1, 0, 0, 0);
        en = 0;
        cyc("wrap_hold", 1,  0, 1, 0, 0, 0);
        en = 1; up = 0; step = 2;
        cyc("wrap_dn",  99,  1, 1, 1, 0, 0);
        en = 0; clr_flags = 1;
        cyc("clr1",     99,  0, 0, 0, 0, 0);

        clr_flags = 0; load = 1; loadin = 2;
        cyc("ld2",      2,   0, 0, 0, 0, 0);
        load = 0; mode = 2'b01; up = 0; step = 5; en = 1;
        cyc("sat1",     0,   1, 0, 1, 0, 1);
        cyc("sat2",     0,   1, 0, 1, 0, 1);
        cyc("sat3",     0,   1, 0, 1, 0, 1);
        en = 0; clr_flags = 1;
        cyc("sat_clr",  0,   0, 0, 0, 0, 1);

        clr_flags = 0; load = 1; loadin = 97;
        cyc("ld97",     97,  0, 0, 0, 0, 0);
        load = 0; loadin = 10; mode = 2'b10; up = 1; step = 5; en = 1;
        cyc("reload",   10,  1, 1, 0, 0, 0);
        cyc("reload+",  15,  0, 1, 0, 0, 0);
        en = 0; clr_flags = 1;
        cyc("clr2",     15,  0, 0, 0, 0, 0);

        clr_flags = 0; load = 1; loadin = 95;
        cyc("ld95",     95,  0, 0, 0, 0, 0);
        load = 0; mode = 2'b11; up = 1; step = 5; en = 1;
        cyc("oneshot",  99,  1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            cyc("os_hold", 99, 0, 1, 0, 1, 0);
        load = 1; loadin = 0;
        cyc("os_ld0",   0,   0, 1, 0, 0, 1);

        mode = 2'b00; up = 1; step = 3; en = 1; load = 1; loadin = 200;
        cyc("ld_clamp", 99,  0, 1, 0, 0, 0);
        load = 0; step = 0; en = 1;
        cyc("step0",    99,  0, 1, 0, 0, 0);
        en = 0; clr_flags = 1;
        cyc("clr3",     99,  0, 0, 0, 0, 0);
        en = 1; step = 1; up = 1; clr_flags = 1;
        cyc("set_wins", 0,   1, 1, 0, 0, 1);

        clr_flags = 0; en = 0; load = 1; loadin = 48; cmp_val = 50;
        cyc("ld48",     48,  0, 1, 0, 0, 0);
        load = 0; en = 1; step = 1; up = 1;
        cyc("m49",      49,  0, 1, 0, 0, 0);
        cyc("m50",      50,  0, 1, 0, 0, 1);
        cyc("m51",      51,  0, 1, 0, 0, 0);

        rst = 1; load = 1; en = 1; loadin = 77;
        cyc("rst_mid",  0,   0, 0, 0, 0, 0);
        rst = 0; load = 0; en = 0;

        tests++;
        assert (eq.size() == 0) else begin
            fails++;
            $error("FAIL sb_empty got=%0d exp=0", eq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/updown_counter_mode.md
Name: updown_counter_mode

Overview:
- Parametrised up/down counter with load, and the next generation of the team's 8-bit up/down/load counter.
- Adds configurable width and modulus, a variable step size, four boundary modes (wrap, saturate, auto-reload, one-shot), a compare output, and terminal-count, overflow and underflow flags.
- Used as a general timer/event counter inside the team's verification-friendly datapath blocks.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_VAL, 2**WIDTH-1, upper count bound; the legal range is 0..MAX_VAL. Must satisfy 2**STEP_W-1 <= MAX_VAL <= 2**WIDTH-1.
- STEP_W, 4, width of the step input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load of loadin.
- loadin  in  WIDTH  load value; also the auto-reload value.
- step  in  STEP_W  increment/decrement amount; 0 = hold.
- mode  in  2  00 wrap, 01 saturate, 10 auto-reload, 11 one-shot.
- clr_flags  in  1  clears the ovf and udf sticky flags.
- cmp_val  in  WIDTH  compare value.
- y  out  WIDTH  count value (registered).
- tc  out  1  terminal-count pulse (registered).
- ovf  out  1  sticky up-boundary flag.
- udf  out  1  sticky down-boundary flag.
- done  out  1  one-shot completed (registered).
- match  out  1  combinational, y == cmp_val.

Behaviour:
- Reset values: y=0, tc=0, ovf=0, udf=0, done=0. match follows y.
- Priority per cycle: rst > load > count > hold.
- Count condition: en=1, step!=0, done=0.
- Load:
  - y <= min(loadin, MAX_VAL).
  - Clears done; tc <= 0.
  - ovf and udf are unaffected except by clr_flags.
- Arithmetic is done in WIDTH+1 bits, with no truncation before comparison.
- Boundary events:
  - Up boundary event: y + step > MAX_VAL.
  - Down boundary event: y < step.
- Count, no boundary event: y <= y ± step.
- Count, boundary event, by mode:
  - 00 wrap: up y <= y + step - (MAX_VAL+1); down y <= y + (MAX_VAL+1) - step.
  - 01 saturate: up y <= MAX_VAL; down y <= 0. A boundary event is still raised every counting cycle while clamped.
  - 10 auto-reload: y <= min(loadin, MAX_VAL), both directions.
  - 11 one-shot: clamp as in saturate and set done <= 1. Counting stops (y holds, tc stays 0) until load or rst.
- tc:
  - Driven to 1 in the cycle following a counting cycle that had a boundary event.
  - Otherwise 0, i.e. a single-cycle pulse per event.
- Sticky flags:
  - ovf is set by an up boundary event; udf by a down boundary event.
  - clr_flags clears both.
  - If a set and clr_flags occur in the same cycle, the set wins.
- Hold (en=0, or step=0, or done=1): y, done, ovf and udf keep their values; tc <= 0.
- Mode, up and step are sampled every cycle. A change takes effect on the same edge, with no internal mode state except done.
- rst mid-count: all outputs return to reset values on the next edge, regardless of load/en.
- match is combinational from registered y, so it has zero added latency.

Test Plan (WIDTH=8, MAX_VAL=99, STEP_W=4):
- rst=1 with load=1, en=1 -> after the edge: y=0, tc=0, ovf=0, udf=0, done=0; match=1 when cmp_val=0.
- Wrap:
  - load 98, then mode=00, up=1, step=3, en=1 for 1 cycle -> y=1, tc=1 for one cycle, ovf=1 (remains 1).
  - Then up=0, step=2 -> y=99, udf=1.
- Saturate: load 2; mode=01, up=0, step=5 for 3 cycles -> y=0,0,0; tc=1 on all 3 cycles; udf=1. Then clr_flags=1 with en=0 -> udf=0.
- Auto-reload: loadin=10, load 97; mode=10, up=1, step=5 -> y=10, tc=1. Next cycle y=15, tc=0.
- One-shot:
  - load 95; mode=11, up=1, step=5 -> y=99, done=1, tc=1.
  - en held 1 for 4 more cycles -> y=99, done=1, tc=0.
  - load=1, loadin=0 -> y=0, done=0.
- Edges:
  - load=1 and en=1 in the same cycle, loadin=200 -> y=99 (load wins, clamped).
  - step=0 with en=1 -> y holds, tc=0.
  - ovf set and clr_flags in the same cycle -> ovf=1.
  - cmp_val=50, counting through 50 -> match=1 exactly while y=50.
